// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_done = enable && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_done ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with valid/ready byte input and a pin output enable.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_oe,
  output logic       busy
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  state_e     state, state_next;
  logic [7:0] shift, shift_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic       bit_done;
  logic       accept;
  logic       last_bit;
  logic       tx_d, ready_d, busy_d;

  // tx_ready is registered and only ever 1 in IDLE with tx_oe already up
  assign accept   = tx_valid && tx_ready && (state == IDLE);
  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state != IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)               state_next = START;
      START:   if (bit_done)             state_next = DATA;
      DATA:    if (bit_done && last_bit) state_next = STOP;
      STOP:    if (bit_done)             state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered pins track it exactly
  always_comb begin
    shift_next   = shift;
    bit_idx_next = bit_idx;
    tx_d         = IDLE_LEVEL;
    ready_d      = 1'b0;
    busy_d       = 1'b0;
    if (accept) begin
      shift_next   = tx_data;
      bit_idx_next = '0;
    end else if (state == DATA && bit_done) begin
      shift_next   = shift >> 1;
      bit_idx_next = last_bit ? bit_idx : bit_idx + 3'd1;
    end
    case (state_next)
      IDLE:  ready_d = 1'b1;
      START: begin tx_d = START_LEVEL;   busy_d = 1'b1; end
      DATA:  begin tx_d = shift_next[0]; busy_d = 1'b1; end
      STOP:  begin tx_d = STOP_LEVEL;    busy_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      bit_idx  <= '0;
      tx       <= IDLE_LEVEL;
      tx_oe    <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      tx       <= tx_d;
      tx_oe    <= 1'b1;
      tx_ready <= ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that drives one bidirectional user IO pin of the tile, e.g. uio_out[0], with its output enable, e.g. uio_oe[0].
- Sends 8-bit bytes as asynchronous frames: 8N1, LSB first, 1 start bit, 1 stop bit.
- Accepts bytes from core logic over a valid/ready handshake.
- Serves as the outbound companion to the tile's dedicated parallel inputs, so results can leave the chip on a single pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal range 2..65535. Elaboration fails outside this range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- tx_data  in  8  byte to send; sampled only on an accepting edge.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_ready  out  1  transmitter can accept a byte this cycle.
- tx  out  1  serial line, idle high; connect to uio_out bit.
- tx_oe  out  1  output enable for the pin; connect to uio_oe bit.
- busy  out  1  high while a frame is on the line (START through STOP).

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - tx=1, tx_oe=0, tx_ready=0, busy=0, state=IDLE, counters=0.
- tx_oe:
  - Goes 1 on the first rising edge after rst deasserts.
  - Stays 1 until the next reset.
  - tx_ready also rises on that same edge.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: tx=1, tx_ready=1 (once tx_oe=1), busy=0.
    - On an edge with tx_valid&tx_ready: latch tx_data into the shift register, go to START.
    - From that edge on: tx=0, tx_ready=0, busy=1.
  - START: hold tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA, bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
    - After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
    - busy=0 and tx_ready=1 from that edge.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles, from the accepting edge to the return to IDLE.
  - Back-to-back: with tx_valid held high, the next frame's start bit begins 1 cycle after STOP ends. Minimum frame period is 10*CLKS_PER_BIT+1 cycles.
- Input handling:
  - tx_data and tx_valid changes during a frame are ignored. The byte is captured only at acceptance.
  - tx_valid during reset or before tx_oe=1 is not accepted.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at every bit boundary.
  - Cleared on acceptance.
- Bit index: 3 bits, counts 0..7, no wrap beyond STOP.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronously), tx_oe=0, and the frame is abandoned.
  - After reset release, behaves as after power-up. No partial frame resumes.
- Unreachable state encodings recover to IDLE on the next edge with tx=1.

Decomposition:
- Package uart_pkg:
  - state enum IDLE, START, DATA, STOP (2 bits).
  - constants DATA_BITS=8, IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- One sub-module: uart_baud_counter.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, clear, enable.
  - Output bit_done: a one-cycle pulse when the count equals CLKS_PER_BIT-1.
- The FSM and shift register stay in uart_tx.

Test Plan:
- All scenarios use CLKS_PER_BIT=4.
- Reset then release: during rst, tx=1, tx_oe=0, tx_ready=0. One edge after release, tx_oe=1 and tx_ready=1. tx stays 1 with no valid.
- Send 0xA5 with a 1-cycle valid pulse: tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. busy is high for 40 cycles. tx_ready returns 1 on cycle 40.
- Send 0x00 then 0xFF with valid held high: second start bit begins exactly 41 cycles after the first acceptance. The data bits are all 0, then all 1.
- Change tx_data to 0x3C in mid-frame after accepting 0x81: the line still carries 0x81 (bits 1,0,0,0,0,0,0,1).
- Assert rst at cycle 17 of a frame for 2 cycles: tx=1 and tx_oe=0 within the same cycle. No further start bit until a new handshake after release.
- CLKS_PER_BIT=2 boundary: send 0x55. Each bit lasts exactly 2 cycles and the frame is 20 cycles.
